// File: rtl/fig_04b_block_078_pkg.sv
// Shared constants and types for the register control block (Fig. 4B block 78)
// and its flag circuit (Fig. 6 block 166).
package fig_04b_block_078_pkg;

  localparam int DATA_W       = 16;
  localparam int NREG_DEF     = 16;
  localparam int ADDR_W       = 4;

  // Register index constants
  localparam int R0           = 0;
  localparam int R15_PC       = 15;

  // Bit positions inside the {OV,S,CY,Z} flags vector
  localparam int FLAG_Z       = 0;
  localparam int FLAG_CY      = 1;
  localparam int FLAG_S       = 2;
  localparam int FLAG_OV      = 3;

  // B prefix state: set by WITH, consumed by the next FROM/TO or plain opcode
  typedef enum logic {
    B_CLEAR = 1'b0,
    B_SET   = 1'b1
  } b_state_e;

  // What an instr_valid edge does to the prefix registers
  typedef enum logic [1:0] {
    ACT_END     = 2'd0,
    ACT_SET_SRC = 2'd1,
    ACT_SET_DST = 2'd2,
    ACT_WITH    = 2'd3
  } pfx_act_e;

  // FROM/TO after WITH become MOVES/MOVE and end the instruction instead of setting a prefix.
  function automatic pfx_act_e prefix_action(input logic is_from, input logic is_to,
                                             input logic is_with, input logic b_set);
    if (is_with)             return ACT_WITH;
    if (is_from && !b_set)   return ACT_SET_SRC;
    if (is_to && !b_set)     return ACT_SET_DST;
    return ACT_END;
  endfunction

endpackage

// File: rtl/fig_04b_block_078_if.sv
// Decoder, ALU and host-side signals of the register control block, bundled.
// slave = the register block, master = the decoder/ALU/host driving it.
interface fig_04b_block_078_if #(
  parameter int W  = 16,
  parameter int AW = 4
);
  logic [7:0]    instr;
  logic          instr_valid;
  logic          is_from;
  logic          is_to;
  logic          is_with;
  logic          wb_en;
  logic          flag_upd;
  logic          cy_upd;
  logic          ov_upd;
  logic          pc_inc;
  logic [W-1:0]  z;
  logic          cy;
  logic          ov;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [3:0]    flags;
  logic [W-1:0]  pc;
  logic          go;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_wdata;
  logic [W-1:0]  host_rdata;
  logic          host_ack;

  modport slave (
    input  instr, instr_valid, is_from, is_to, is_with, wb_en,
    input  flag_upd, cy_upd, ov_upd, pc_inc, z, cy, ov,
    input  go, host_we, host_addr, host_wdata,
    output x, y, flags, pc, host_rdata, host_ack
  );

  modport master (
    output instr, instr_valid, is_from, is_to, is_with, wb_en,
    output flag_upd, cy_upd, ov_upd, pc_inc, z, cy, ov,
    output go, host_we, host_addr, host_wdata,
    input  x, y, flags, pc, host_rdata, host_ack
  );
endinterface

// File: rtl/fig_06_block_166.sv
// Flag circuit: registered {OV,S,CY,Z}, each group updated only on an instruction
// edge when its enable is set, otherwise held.
module fig_06_block_166
  import fig_04b_block_078_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upd_en,
  input  logic         flag_upd,
  input  logic         cy_upd,
  input  logic         ov_upd,
  input  logic [W-1:0] z,
  input  logic         cy,
  input  logic         ov,
  output logic [3:0]   flags
);

  logic [3:0] flags_q, flags_d;

  // NOTE: default every always_comb output first so no path can infer a latch.
  always_comb begin
    flags_d = flags_q;
    if (upd_en) begin
      if (flag_upd) begin
        flags_d[FLAG_Z] = (z == '0);
        flags_d[FLAG_S] = z[W-1];
      end
      if (cy_upd) flags_d[FLAG_CY] = cy;
      if (ov_upd) flags_d[FLAG_OV] = ov;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: rtl/fig_04b_block_078.sv
// Register control block: R0-R15 (R15 = PC), Sreg/Dreg/B prefix state, ALU operand
// read ports, z writeback, host register access and the flag circuit.
module fig_04b_block_078
  import fig_04b_block_078_pkg::*;
#(
  parameter int           W        = DATA_W,
  parameter int           NREG     = NREG_DEF,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  fig_04b_block_078_if.slave    bus
);

  localparam int AW     = $clog2(NREG);
  localparam int PC_IDX = NREG - 1;

  logic [W-1:0]  regs_q [NREG];
  logic [W-1:0]  regs_d [NREG];
  logic [AW-1:0] sreg_q, sreg_d;
  logic [AW-1:0] dreg_q, dreg_d;
  b_state_e      b_q, b_d;
  logic          host_ack_q, host_ack_d;

  logic [AW-1:0] instr_idx;
  logic          core_wr;
  logic          host_wr;
  pfx_act_e      pfx_act;
  logic          unused_instr_hi;

  assign instr_idx       = bus.instr[AW-1:0];
  assign unused_instr_hi = ^bus.instr[7:AW];
  assign core_wr         = bus.wb_en && bus.instr_valid;
  assign host_wr         = !bus.go && bus.host_we;
  assign pfx_act         = prefix_action(bus.is_from, bus.is_to, bus.is_with, b_q == B_SET);

  // Prefix state: the writeback below still sees the pre-clear dreg_q.
  always_comb begin
    sreg_d = sreg_q;
    dreg_d = dreg_q;
    b_d    = b_q;
    if (bus.instr_valid) begin
      unique case (pfx_act)
        ACT_WITH: begin
          sreg_d = instr_idx;
          dreg_d = instr_idx;
          b_d    = B_SET;
        end
        ACT_SET_SRC: sreg_d = instr_idx;
        ACT_SET_DST: dreg_d = instr_idx;
        default: begin
          sreg_d = '0;
          dreg_d = '0;
          b_d    = B_CLEAR;
        end
      endcase
    end
  end

  // Later assignments take priority: PC increment < host write < core writeback.
  always_comb begin
    regs_d = regs_q;
    if (bus.pc_inc) regs_d[PC_IDX] = regs_q[PC_IDX] + 1'b1;
    if (host_wr)    regs_d[bus.host_addr] = bus.host_wdata;
    if (core_wr)    regs_d[dreg_q] = bus.z;
  end

  assign host_ack_d = host_wr;

  // NOTE: this register file needs a defined reset value per entry, so it is
  // built from flops with a reset loop rather than inferred as a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= (i == PC_IDX) ? RESET_PC : '0;
      sreg_q     <= '0;
      dreg_q     <= '0;
      b_q        <= B_CLEAR;
      host_ack_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      sreg_q     <= sreg_d;
      dreg_q     <= dreg_d;
      b_q        <= b_d;
      host_ack_q <= host_ack_d;
    end
  end

  assign bus.x          = regs_q[sreg_q];
  assign bus.y          = regs_q[instr_idx];
  assign bus.pc         = regs_q[PC_IDX];
  assign bus.host_rdata = regs_q[bus.host_addr];
  assign bus.host_ack   = host_ack_q;

  fig_06_block_166 #(.W(W)) u_flags (
    .clk      (clk),
    .rst      (rst),
    .upd_en   (bus.instr_valid),
    .flag_upd (bus.flag_upd),
    .cy_upd   (bus.cy_upd),
    .ov_upd   (bus.ov_upd),
    .z        (bus.z),
    .cy       (bus.cy),
    .ov       (bus.ov),
    .flags    (bus.flags)
  );

endmodule
